pcie_skp_scheduler: RTL

Per-link SKP ordered-set scheduler. It sits between the symbol-level TX packet source and the lane striper/encoder of a PcieVhost-style link. It counts symbol times and accumulates pending SKP requests. At the next packet boundary it stalls the source and injects COM followed by SKP_COUNT SKP symbols. This keeps SKP insertion on the link compliant regardless of traffic.

---
 rtl/pcie_skp_scheduler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pcie_skp_scheduler.sv
// SKP ordered-set scheduler: counts symbol times, queues SKP requests and injects
// COM + SKP_COUNT SKP symbols between packets, stalling the TX source meanwhile.
module pcie_skp_scheduler #(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_COUNT    = 3,
  parameter int PEND_MAX     = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Enable,
  input  logic [8:0] InData,
  input  logic       InValid,
  input  logic       InEop,
  output logic       InReady,
  output logic [8:0] OutData,
  output logic       OutValid,
  input  logic       OutReady,
  output logic       SkpActive,
  output logic [1:0] Pending,
  output logic       Overflow
);

  localparam int CNT_W = (SKP_INTERVAL > 2) ? $clog2(SKP_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SKP_INTERVAL - 1);
  localparam logic [2:0]       SYM_LAST = 3'(SKP_COUNT);
  localparam logic [1:0]       PEND_SAT = 2'(PEND_MAX);
  localparam logic [8:0]       SYM_COM  = 9'h1BC;
  localparam logic [8:0]       SYM_SKP  = 9'h11C;

  typedef enum logic {PASS, INSERT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             inpkt_q, inpkt_d;
  logic [2:0]       sym_q, sym_d;

  logic             req;
  logic             dec;
  logic             sat;
  logic             in_ready;
  logic             out_valid;
  logic [8:0]       out_data;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= PASS;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      inpkt_q <= 1'b0;
      sym_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      inpkt_q <= inpkt_d;
      sym_q   <= sym_d;
    end
  end

  // Interval counter and pending-request bookkeeping
  always_comb begin
    req    = Enable && (cnt_q == CNT_LAST);
    dec    = (state_q == INSERT) && OutReady && (sym_q == SYM_LAST);
    sat    = (pend_q == PEND_SAT);
    cnt_d  = cnt_q;
    pend_d = pend_q;
    ovf_d  = ovf_q | (req & sat);

    if (!Enable) begin
      cnt_d  = '0;
      pend_d = '0;
    end else begin
      cnt_d = req ? '0 : cnt_q + CNT_W'(1);
      if (req && !dec) begin
        if (!sat) pend_d = pend_q + 2'd1;
      end else if (dec && !req) begin
        // Enable may have cleared Pending while this ordered set was in flight
        if (pend_q != 2'd0) pend_d = pend_q - 2'd1;
      end
    end
  end

  // Symbol path: pass-through, bubble, or ordered-set injection
  always_comb begin
    state_d   = state_q;
    sym_d     = sym_q;
    inpkt_d   = inpkt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;

    unique case (state_q)
      PASS: begin
        if (Enable && (pend_q != 2'd0) && !inpkt_q) begin
          state_d = INSERT;
          sym_d   = '0;
        end else begin
          out_data  = InData;
          out_valid = InValid;
          in_ready  = OutReady;
          if (InValid && OutReady) inpkt_d = !InEop;
        end
      end
      INSERT: begin
        out_valid = 1'b1;
        out_data  = (sym_q == 3'd0) ? SYM_COM : SYM_SKP;
        if (OutReady) begin
          if (sym_q == SYM_LAST) begin
            state_d = PASS;
            sym_d   = '0;
          end else begin
            sym_d = sym_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = PASS;
        sym_d   = '0;
      end
    endcase
  end

  assign InReady   = in_ready & ~Reset;
  assign OutValid  = out_valid & ~Reset;
  assign OutData   = Reset ? 9'h000 : out_data;
  assign SkpActive = (state_q == INSERT) & ~Reset;
  assign Pending   = pend_q;
  assign Overflow  = ovf_q;

endmodule
